// File: rtl/gba_audio_pwm_sampler.sv
// GBA PWM audio pins -> signed 16-bit stereo PCM at a fixed sample rate, pixel-clock domain.
// Integrates +1/-1 per cycle over a phase-accumulator window, scales, saturates, valid/ready out.
module gba_audio_pwm_sampler #(
  parameter int CLK_FRQ     = 74250000,
  parameter int SAMPLE_RATE = 48000,
  parameter int SHIFT       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               audioLIn,
  input  logic               audioRIn,
  input  logic               sampleReady,
  output logic signed [15:0] audioLOut,
  output logic signed [15:0] audioROut,
  output logic               sampleValid,
  output logic               overrun
);

  localparam int ACC_W = $clog2(CLK_FRQ) + 1;
  localparam int CNT_W = $clog2(CLK_FRQ / SAMPLE_RATE) + 2;
  // Headroom so the shifted sum never wraps before saturation.
  localparam int SUM_W = CNT_W + SHIFT + 17;

  localparam logic [ACC_W-1:0]        ACC_STEP = ACC_W'(SAMPLE_RATE);
  localparam logic [ACC_W-1:0]        ACC_WRAP = ACC_W'(CLK_FRQ);
  localparam logic signed [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic signed [CNT_W-1:0] CNT_NEG  = '1;
  localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_MIN  = SUM_W'(-32768);

  logic [1:0]              lSync;
  logic [1:0]              rSync;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        accNxt;
  logic                    tick;
  logic signed [CNT_W-1:0] lCnt;
  logic signed [CNT_W-1:0] rCnt;
  logic signed [CNT_W-1:0] lSum;
  logic signed [CNT_W-1:0] rSum;

  function automatic logic signed [15:0] scaleSat(input logic signed [CNT_W-1:0] sum);
    logic signed [SUM_W-1:0] wide;
    wide = SUM_W'(sum);
    wide = wide <<< SHIFT;
    if (wide > SAT_MAX)
      return 16'sh7fff;
    else if (wide < SAT_MIN)
      return 16'sh8000;
    else
      return 16'(wide);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lSync <= '0;
      rSync <= '0;
    end else begin
      lSync <= {lSync[0], audioLIn};
      rSync <= {rSync[0], audioRIn};
    end
  end

  always_comb begin
    accNxt = acc + ACC_STEP;
    tick   = (accNxt >= ACC_WRAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (tick)
      acc <= accNxt - ACC_WRAP;
    else
      acc <= accNxt;
  end

  // The tick cycle's own contribution belongs to the window it closes.
  always_comb begin
    lSum = lCnt + (lSync[1] ? CNT_ONE : CNT_NEG);
    rSum = rCnt + (rSync[1] ? CNT_ONE : CNT_NEG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lCnt <= '0;
      rCnt <= '0;
    end else if (tick) begin
      lCnt <= '0;
      rCnt <= '0;
    end else begin
      lCnt <= lSum;
      rCnt <= rSum;
    end
  end

  // A tick always wins: newest sample is loaded even if the old one was never taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audioLOut   <= '0;
      audioROut   <= '0;
      sampleValid <= 1'b0;
      overrun     <= 1'b0;
    end else if (tick) begin
      audioLOut   <= scaleSat(lSum);
      audioROut   <= scaleSat(rSum);
      sampleValid <= 1'b1;
      overrun     <= sampleValid & ~sampleReady;
    end else begin
      overrun <= 1'b0;
      if (sampleValid && sampleReady)
        sampleValid <= 1'b0;
    end
  end

endmodule
